// File: rtl/sb_dmem_slv_pkg.sv
// Shared definitions for the system-bus data-memory slave: bus widths,
// lane helpers and the write-buffer operation encoding.
package sb_dmem_slv_pkg;

  localparam logic [31:0] ZERO32         = 32'h0000_0000;
  localparam int          DATA_WIDTH     = 32;
  localparam int          MEM_ADDR_WIDTH = 12;
  localparam int          BYTE_SEL       = 2;
  localparam int          SB_LANES       = 4;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_MERGE,
    WB_LOAD,
    WB_DRAIN
  } wb_op_e;

  // Strobe lanes that sit below the byte offset; any of them set means the
  // access would run off the end of the word.
  function automatic logic [SB_LANES-1:0] lane_mask(input logic [BYTE_SEL-1:0] off);
    return (4'd1 << off) - 4'd1;
  endfunction

endpackage

// File: rtl/sb_dmem_array.sv
// Word array with per-byte write enables: asynchronous read, synchronous write,
// no reset (contents are undefined until written).
module sb_dmem_array
  import sb_dmem_slv_pkg::*;
#(
  parameter int AW = MEM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic [SB_LANES-1:0]   we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    for (int i = 0; i < SB_LANES; i++) begin
      if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sb_dmem_slv.sv
// Memory-side responder for the system-bus slave port: address decode, a
// one-entry merging write buffer with read forwarding, error flag and merge counter.
module sb_dmem_slv
  import sb_dmem_slv_pkg::*;
#(
  parameter  int          AW      = MEM_ADDR_WIDTH,
  parameter  logic [31:0] BASE    = 32'h0000_0000,
  localparam int          ERR_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SB_LANES-1:0]   s_rw_i,
  input  logic [31:0]           s_addr_i,
  input  logic [DATA_WIDTH-1:0] s_wdata_i,
  output logic [DATA_WIDTH-1:0] s_rdata_o,
  output logic                  s_err_o,
  output logic                  wb_busy_o,
  output logic [15:0]           merge_cnt_o
);

  logic [BYTE_SEL-1:0]   off;
  logic [31:0]           rel_addr;
  logic [31:0]           widx_full;
  logic [AW-1:0]         idx;
  logic                  in_range;
  logic                  is_wr;
  logic                  misaligned;
  logic                  wr_ok;
  logic                  hit;
  logic                  err_next;
  logic [SB_LANES-1:0]   be;
  logic [DATA_WIDTH-1:0] wdata_sh;
  logic [DATA_WIDTH-1:0] mem_word;
  logic [DATA_WIDTH-1:0] fwd_word;
  logic [SB_LANES-1:0]   mem_we;
  wb_op_e                op;

  logic                  wb_valid;
  logic [AW-1:0]         wb_idx;
  logic [SB_LANES-1:0]   wb_be;
  logic [DATA_WIDTH-1:0] wb_data;
  logic [ERR_LAT-1:0]    err_q;
  logic [15:0]           merge_cnt;

  assign off        = s_addr_i[BYTE_SEL-1:0];
  assign rel_addr   = s_addr_i - BASE;
  assign widx_full  = rel_addr >> 2;
  assign idx        = widx_full[AW-1:0];
  assign in_range   = (s_addr_i >= BASE) && (widx_full[31:AW] == '0);
  assign is_wr      = |s_rw_i;
  assign misaligned = |(s_rw_i & lane_mask(off));
  assign wr_ok      = is_wr && !misaligned && in_range;
  assign err_next   = is_wr ? (misaligned || !in_range) : !in_range;
  assign be         = s_rw_i >> off;
  assign wdata_sh   = s_wdata_i >> {off, 3'b000};
  assign hit        = wb_valid && (wb_idx == idx);

  // Decide what the buffer does at the next edge; it drains on any non-write cycle.
  always_comb begin
    op = WB_IDLE;
    if (wr_ok && hit)  op = WB_MERGE;
    else if (wr_ok)    op = WB_LOAD;
    else if (wb_valid) op = WB_DRAIN;
  end

  assign mem_we = (wb_valid && (op == WB_LOAD || op == WB_DRAIN)) ? wb_be : '0;

  sb_dmem_array #(.AW(AW)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wb_idx),
    .wdata (wb_data),
    .raddr (idx),
    .rdata (mem_word)
  );

  always_comb begin
    fwd_word = mem_word;
    for (int i = 0; i < SB_LANES; i++) begin
      if (hit && wb_be[i]) fwd_word[8*i +: 8] = wb_data[8*i +: 8];
    end
  end

  assign s_rdata_o   = in_range ? (fwd_word << {off, 3'b000}) : ZERO32;
  assign s_err_o     = err_q[ERR_LAT-1];
  assign wb_busy_o   = wb_valid;
  assign merge_cnt_o = merge_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid  <= 1'b0;
      wb_idx    <= '0;
      wb_be     <= '0;
      wb_data   <= '0;
      err_q     <= '0;
      merge_cnt <= '0;
    end else begin
      err_q[0] <= err_next;
      case (op)
        WB_MERGE: begin
          wb_be <= wb_be | be;
          for (int i = 0; i < SB_LANES; i++) begin
            if (be[i]) wb_data[8*i +: 8] <= wdata_sh[8*i +: 8];
          end
          if (merge_cnt != 16'hFFFF) merge_cnt <= merge_cnt + 16'd1;
        end
        WB_LOAD: begin
          wb_valid <= 1'b1;
          wb_idx   <= idx;
          wb_be    <= be;
          wb_data  <= wdata_sh;
        end
        WB_DRAIN: wb_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sb_dmem_slv.sv
// Scoreboard bench for sb_dmem_slv: directed bus cycles push expected values,
// a negedge monitor pops the ones due in that cycle and compares them.
module tb_sb_dmem_slv;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  s_rw_i;
  logic [31:0] s_addr_i;
  logic [31:0] s_wdata_i;
  logic [31:0] s_rdata_o;
  logic        s_err_o;
  logic        wb_busy_o;
  logic [15:0] merge_cnt_o;

  localparam int SIG_RDATA = 0;
  localparam int SIG_ERR   = 1;
  localparam int SIG_BUSY  = 2;
  localparam int SIG_CNT   = 3;

  typedef struct {
    int          due;
    int          sig;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   mc     = 0;

  sb_dmem_slv u_dut (
    .clk         (clk),
    .rst         (rst),
    .s_rw_i      (s_rw_i),
    .s_addr_i    (s_addr_i),
    .s_wdata_i   (s_wdata_i),
    .s_rdata_o   (s_rdata_o),
    .s_err_o     (s_err_o),
    .wb_busy_o   (wb_busy_o),
    .merge_cnt_o (merge_cnt_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation that falls due in this cycle.
  always @(negedge clk) begin
    int i;
    logic [31:0] act;
    i = 0;
    while (i < q.size()) begin
      if (q[i].due <= cyc) begin
        case (q[i].sig)
          SIG_RDATA: act = s_rdata_o;
          SIG_ERR:   act = {31'b0, s_err_o};
          SIG_BUSY:  act = {31'b0, wb_busy_o};
          default:   act = {16'b0, merge_cnt_o};
        endcase
        checks++;
        if (q[i].due < cyc) begin
          errors++;
          $display("[TB] FAIL %s: missed its cycle (due %0d, now %0d)", q[i].name, q[i].due, cyc);
        end else if (act !== q[i].exp) begin
          errors++;
          $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", q[i].name, act, q[i].exp, cyc);
        end
        q.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic checkOutput(input int sig, input logic [31:0] exp, input int delay,
                             input string name);
    exp_t e;
    e.due  = cyc + delay;
    e.sig  = sig;
    e.exp  = exp;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic applyStimulus(input logic [3:0] rw, input logic [31:0] addr,
                               input logic [31:0] wdata);
    @(posedge clk);
    #1;
    s_rw_i    = rw;
    s_addr_i  = addr;
    s_wdata_i = wdata;
  endtask

  initial begin
    rst       = 1'b0;
    s_rw_i    = '0;
    s_addr_i  = '0;
    s_wdata_i = '0;

    // Reset held with random bus activity
    repeat (3) begin
      @(posedge clk);
      #1;
      s_rw_i    = 4'($urandom);
      s_addr_i  = $urandom;
      s_wdata_i = $urandom;
      checkOutput(SIG_ERR,  32'd0, 0, "rst_err");
      checkOutput(SIG_BUSY, 32'd0, 0, "rst_busy");
      checkOutput(SIG_CNT,  32'd0, 0, "rst_cnt");
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    s_rw_i = '0; s_addr_i = '0; s_wdata_i = '0;

    // Word write then read
    applyStimulus(4'hF, 32'h10, 32'h1122_3344);
    checkOutput(SIG_BUSY, 32'd1, 1, "wr_busy");
    checkOutput(SIG_ERR,  32'd0, 1, "wr_err");
    applyStimulus(4'h0, 32'h10, 32'h0);
    checkOutput(SIG_RDATA, 32'h1122_3344, 0, "rd_fwd");
    checkOutput(SIG_BUSY,  32'd0, 1, "rd_drain");
    applyStimulus(4'h0, 32'h10, 32'h0);
    checkOutput(SIG_RDATA, 32'h1122_3344, 0, "rd_array");

    // Merge over a zeroed word
    applyStimulus(4'hF, 32'h20, 32'h0);
    checkOutput(SIG_BUSY, 32'd1, 1, "zero_busy");
    applyStimulus(4'h0, 32'h10, 32'h0);
    checkOutput(SIG_RDATA, 32'h1122_3344, 0, "rd_other");
    applyStimulus(4'h8, 32'h21, 32'hAA00_0000);
    checkOutput(SIG_BUSY, 32'd1, 1, "mrg_busy");
    applyStimulus(4'h8, 32'h22, 32'hBB00_0000);
    mc = mc + 1;
    checkOutput(SIG_CNT, 32'(mc), 1, "mrg_cnt");
    applyStimulus(4'h0, 32'h20, 32'h0);
    checkOutput(SIG_RDATA, 32'h00AA_BB00, 0, "mrg_rd20");
    applyStimulus(4'h0, 32'h22, 32'h0);
    checkOutput(SIG_RDATA, 32'hBB00_0000, 0, "mrg_rd22");
    applyStimulus(4'h0, 32'h21, 32'h0);
    checkOutput(SIG_RDATA, 32'hAABB_0000, 0, "mrg_rd21");

    // Misaligned halfword dropped, aligned one accepted
    applyStimulus(4'hC, 32'h13, 32'h9988_0000);
    checkOutput(SIG_ERR,  32'd1, 1, "mis_err");
    checkOutput(SIG_BUSY, 32'd0, 1, "mis_busy");
    applyStimulus(4'h0, 32'h10, 32'h0);
    checkOutput(SIG_RDATA, 32'h1122_3344, 0, "mis_unchanged");
    checkOutput(SIG_ERR,   32'd0, 1, "mis_err_clr");
    applyStimulus(4'hC, 32'h12, 32'h9988_0000);
    checkOutput(SIG_ERR,  32'd0, 1, "hw_err");
    checkOutput(SIG_BUSY, 32'd1, 1, "hw_busy");
    applyStimulus(4'h0, 32'h10, 32'h0);
    checkOutput(SIG_RDATA, 32'h1122_9988, 0, "hw_rd10");
    applyStimulus(4'h0, 32'h12, 32'h0);
    checkOutput(SIG_RDATA, 32'h9988_0000, 0, "hw_rd12");

    // Back-to-back writes to different words
    applyStimulus(4'hF, 32'h0, 32'hA0A0_A0A0);
    applyStimulus(4'hF, 32'h4, 32'hB1B1_B1B1);
    checkOutput(SIG_BUSY, 32'd1, 1, "b2b_busy");
    applyStimulus(4'hF, 32'h8, 32'hC2C2_C2C2);
    checkOutput(SIG_CNT, 32'(mc), 1, "b2b_cnt");
    applyStimulus(4'h0, 32'h0, 32'h0);
    checkOutput(SIG_RDATA, 32'hA0A0_A0A0, 0, "b2b_rd0");
    applyStimulus(4'h0, 32'h4, 32'h0);
    checkOutput(SIG_RDATA, 32'hB1B1_B1B1, 0, "b2b_rd4");
    applyStimulus(4'h0, 32'h8, 32'h0);
    checkOutput(SIG_RDATA, 32'hC2C2_C2C2, 0, "b2b_rd8");
    applyStimulus(4'h0, 32'h5, 32'h0);
    checkOutput(SIG_RDATA, 32'hB1B1_B100, 0, "b2b_rd5");

    // Out-of-range read and write
    applyStimulus(4'h0, 32'h4000, 32'h0);
    checkOutput(SIG_RDATA, 32'h0, 0, "oor_rdata");
    checkOutput(SIG_ERR,   32'd1, 1, "oor_rd_err");
    applyStimulus(4'hF, 32'h4000, 32'hCAFE_F00D);
    checkOutput(SIG_ERR,  32'd1, 1, "oor_wr_err");
    checkOutput(SIG_BUSY, 32'd0, 1, "oor_wr_busy");
    applyStimulus(4'h0, 32'h0, 32'h0);
    checkOutput(SIG_RDATA, 32'hA0A0_A0A0, 0, "oor_no_alias");
    checkOutput(SIG_ERR,   32'd0, 1, "oor_err_clr");

    // Reset while an entry is buffered loses that entry
    applyStimulus(4'hF, 32'hC, 32'h5555_AAAA);
    applyStimulus(4'h0, 32'hC, 32'h0);
    checkOutput(SIG_RDATA, 32'h5555_AAAA, 0, "pre_rst_rd");
    applyStimulus(4'hF, 32'hC, 32'hDEAD_BEEF);
    checkOutput(SIG_BUSY, 32'd1, 1, "pre_rst_busy");
    applyStimulus(4'h0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    mc  = 0;
    checkOutput(SIG_BUSY, 32'd0, 1, "rst_mid_busy");
    checkOutput(SIG_CNT,  32'd0, 1, "rst_mid_cnt");
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(4'h0, 32'hC, 32'h0);
    checkOutput(SIG_RDATA, 32'h5555_AAAA, 0, "rst_lost");
    checkOutput(SIG_ERR,   32'd0, 1, "rst_lost_err");

    repeat (3) applyStimulus(4'h0, 32'h0, 32'h0);
    @(negedge clk);
    #2;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL leftover: %0d pending expectations, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
